// File: rtl/simd_addsub_pkg.sv
// simd_addsub_pkg: op encoding and lane helpers for the SIMD add/sub pipeline.
// Helpers work on the widest supported lane (24 bits); callers truncate.
package simd_addsub_pkg;

    localparam logic OP_ADD  = 1'b0;
    localparam logic OP_SUB  = 1'b1;

    localparam int   MAX_W   = 24;
    localparam int   MAX_BUS = 8 * MAX_W;

    // Largest positive value of a w-bit signed lane.
    function automatic logic [MAX_W-1:0] sat_max(input int w);
        return (24'd1 << (w - 1)) - 24'd1;
    endfunction

    // Most negative value of a w-bit signed lane (bit pattern 100..0).
    function automatic logic [MAX_W-1:0] sat_min(input int w);
        return 24'd1 << (w - 1);
    endfunction

    // Extract lane idx of width w from a packed bus.
    function automatic logic [MAX_W-1:0] lane_get(
        input logic [MAX_BUS-1:0] bus,
        input int                 idx,
        input int                 w
    );
        return MAX_W'(bus >> (idx * w));
    endfunction

endpackage

// File: rtl/simd_lane_addsub_pipe_if.sv
// simd_lane_addsub_pipe_if: input beat stream (s_*) and result stream (m_*).
// slave = the pipeline's view, master = the producer/consumer view.
interface simd_lane_addsub_pipe_if #(
    parameter int LANES = 4,
    parameter int WIDTH = 12
);
    logic                   s_valid;
    logic                   s_ready;
    logic [LANES*WIDTH-1:0] s_a;
    logic [LANES*WIDTH-1:0] s_b;
    logic [LANES-1:0]       s_op;
    logic                   s_sat;

    logic                   m_valid;
    logic                   m_ready;
    logic [LANES*WIDTH-1:0] m_res;
    logic [LANES-1:0]       m_ovf;

    modport slave (
        input  s_valid, s_a, s_b, s_op, s_sat, m_ready,
        output s_ready, m_valid, m_res, m_ovf
    );

    modport master (
        output s_valid, s_a, s_b, s_op, s_sat, m_ready,
        input  s_ready, m_valid, m_res, m_ovf
    );
endinterface

// File: rtl/simd_lane_alu.sv
// simd_lane_alu: one signed lane, combinational add/sub with overflow flag.
// Ports: a, b operands; op 0=add 1=sub; sat enables clamping; res, ovf out.
module simd_lane_alu
    import simd_addsub_pkg::*;
#(
    parameter int WIDTH    = 12,
    parameter bit SATURATE = 1'b1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    input  logic             sat,
    output logic [WIDTH-1:0] res,
    output logic             ovf
);
    logic [WIDTH:0] ax;
    logic [WIDTH:0] bx;
    logic [WIDTH:0] r;

    always_comb begin
        ax = {a[WIDTH-1], a};
        bx = {b[WIDTH-1], b};
        case (op)
            OP_ADD:  r = ax + bx;
            OP_SUB:  r = ax - bx;
            default: r = ax + bx;
        endcase
        // r[WIDTH] is the true sign; a mismatch with r[WIDTH-1] means overflow
        ovf = r[WIDTH] ^ r[WIDTH-1];
        res = r[WIDTH-1:0];
        if (SATURATE && sat && ovf)
            res = r[WIDTH] ? WIDTH'(sat_min(WIDTH))
                           : WIDTH'(sat_max(WIDTH));
    end
endmodule

// File: rtl/simd_lane_addsub_pipe.sv
// simd_lane_addsub_pipe: LANES x WIDTH signed add/sub, valid/ready pipeline.
// Ports: clk, aresetn (async low), sync_clr (flush), bus (slave stream if).
module simd_lane_addsub_pipe
    import simd_addsub_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int WIDTH       = 12,
    parameter int PIPE_STAGES = 2,
    parameter bit SATURATE    = 1'b1
) (
    input  logic                    clk,
    input  logic                    aresetn,
    input  logic                    sync_clr,
    simd_lane_addsub_pipe_if.slave  bus
);
    localparam int BW = LANES * WIDTH;

    logic [PIPE_STAGES:1] v;
    logic [PIPE_STAGES:1] ld;
    logic                 tail_full;
    logic                 accept;

    logic [BW-1:0]        a1;
    logic [BW-1:0]        b1;
    logic [LANES-1:0]     op1;
    logic                 sat1;

    logic [BW-1:0]        rq [2:PIPE_STAGES];
    logic [LANES-1:0]     oq [2:PIPE_STAGES];

    logic [BW-1:0]        alu_res;
    logic [LANES-1:0]     alu_ovf;

    // Stage k may load unless it and every stage after it are full
    // and the consumer is stalling; this collapses bubbles.
    always_comb begin
        tail_full = !bus.m_ready;
        ld        = '0;
        for (int k = PIPE_STAGES; k >= 1; k--) begin
            tail_full = tail_full && v[k];
            ld[k]     = !tail_full;
        end
    end

    assign bus.s_ready = ld[1] && !sync_clr;
    assign accept      = bus.s_valid && bus.s_ready;
    assign bus.m_valid = v[PIPE_STAGES];
    assign bus.m_res   = rq[PIPE_STAGES];
    assign bus.m_ovf   = oq[PIPE_STAGES];

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            v <= '0;
        end else if (sync_clr) begin
            v <= '0;
        end else begin
            if (ld[1])
                v[1] <= bus.s_valid;
            for (int k = 2; k <= PIPE_STAGES; k++)
                if (ld[k])
                    v[k] <= v[k-1];
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            a1   <= '0;
            b1   <= '0;
            op1  <= '0;
            sat1 <= 1'b0;
            for (int k = 2; k <= PIPE_STAGES; k++) begin
                rq[k] <= '0;
                oq[k] <= '0;
            end
        end else begin
            if (accept) begin
                a1   <= bus.s_a;
                b1   <= bus.s_b;
                op1  <= bus.s_op;
                sat1 <= bus.s_sat;
            end
            if (ld[2] && v[1]) begin
                rq[2] <= alu_res;
                oq[2] <= alu_ovf;
            end
            for (int k = 3; k <= PIPE_STAGES; k++)
                if (ld[k] && v[k-1]) begin
                    rq[k] <= rq[k-1];
                    oq[k] <= oq[k-1];
                end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [WIDTH-1:0] la;
        logic [WIDTH-1:0] lb;

        assign la = WIDTH'(lane_get(MAX_BUS'(a1), i, WIDTH));
        assign lb = WIDTH'(lane_get(MAX_BUS'(b1), i, WIDTH));

        simd_lane_alu #(
            .WIDTH    (WIDTH),
            .SATURATE (SATURATE)
        ) u_alu (
            .a   (la),
            .b   (lb),
            .op  (op1[i]),
            .sat (sat1),
            .res (alu_res[i*WIDTH +: WIDTH]),
            .ovf (alu_ovf[i])
        );
    end
endmodule

// File: tb/tb_simd_lane_addsub_pipe.sv
// tb_simd_lane_addsub_pipe: directed and scoreboard checks of the add/sub pipe.
// Three 4x12 instances (PIPE_STAGES 2,3,4) share inputs; one 8x16 wrap-only.
module tb_simd_lane_addsub_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        aresetn;
    logic        sync_clr;
    logic        s_valid;
    logic        s_sat;
    logic [47:0] s_a;
    logic [47:0] s_b;
    logic [3:0]  s_op;
    logic [2:0]  mr;
    logic [2:0]  rdy;
    logic [2:0]  mv;
    logic [47:0] mres [3];
    logic [3:0]  movf [3];

    logic         v8, mr8, rdy8, mv8;
    logic [127:0] a8, b8, mres8;
    logic [7:0]   op8, movf8;

    int checks = 0;
    int fails  = 0;

    logic [51:0] expq [3][1024];
    int          wr [3];
    int          rd [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        simd_lane_addsub_pipe_if #(.LANES(4), .WIDTH(12)) bus ();

        assign bus.s_valid = s_valid;
        assign bus.s_a     = s_a;
        assign bus.s_b     = s_b;
        assign bus.s_op    = s_op;
        assign bus.s_sat   = s_sat;
        assign bus.m_ready = mr[g];
        assign rdy[g]      = bus.s_ready;
        assign mv[g]       = bus.m_valid;
        assign mres[g]     = bus.m_res;
        assign movf[g]     = bus.m_ovf;

        simd_lane_addsub_pipe #(
            .LANES(4), .WIDTH(12), .PIPE_STAGES(g + 2), .SATURATE(1'b1)
        ) u_dut (
            .clk(clk), .aresetn(aresetn), .sync_clr(sync_clr), .bus(bus)
        );
    end

    simd_lane_addsub_pipe_if #(.LANES(8), .WIDTH(16)) bus8 ();

    assign bus8.s_valid = v8;
    assign bus8.s_a     = a8;
    assign bus8.s_b     = b8;
    assign bus8.s_op    = op8;
    assign bus8.s_sat   = s_sat;
    assign bus8.m_ready = mr8;
    assign rdy8         = bus8.s_ready;
    assign mv8          = bus8.m_valid;
    assign mres8        = bus8.m_res;
    assign movf8        = bus8.m_ovf;

    simd_lane_addsub_pipe #(
        .LANES(8), .WIDTH(16), .PIPE_STAGES(2), .SATURATE(1'b0)
    ) u_dut8 (
        .clk(clk), .aresetn(aresetn), .sync_clr(sync_clr), .bus(bus8)
    );

    // Integer reference model for the 4x12 configuration: {ovf, res}.
    function automatic logic [51:0] model(
        input logic [47:0] a, input logic [47:0] b,
        input logic [3:0] op, input logic sat
    );
        logic [47:0] r;
        logic [3:0]  o;
        int          x, y, s;
        for (int i = 0; i < 4; i++) begin
            x = int'($signed(a[i*12 +: 12]));
            y = int'($signed(b[i*12 +: 12]));
            s = op[i] ? x - y : x + y;
            o[i] = (s > 2047) || (s < -2048);
            if (o[i] && sat)
                s = (s > 0) ? 2047 : -2048;
            r[i*12 +: 12] = s[11:0];
        end
        return {o, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        s_valid  = 1'b0;
        sync_clr = 1'b1;
        tick();
        sync_clr = 1'b0;
    endtask

    task automatic clear_sb();
        for (int g = 0; g < 3; g++) begin
            wr[g] = 0;
            rd[g] = 0;
        end
    endtask

    // Pushes one beat into the PIPE_STAGES=2 instance and returns its result.
    task automatic one_beat(
        input  logic [47:0] a, input logic [47:0] b,
        input  logic [3:0] op, input logic sat,
        output logic [47:0] r, output logic [3:0] o, output logic got
    );
        mr      = 3'b111;
        s_valid = 1'b1;
        s_a     = a;
        s_b     = b;
        s_op    = op;
        s_sat   = sat;
        tick();
        s_valid = 1'b0;
        got     = 1'b0;
        r       = '0;
        o       = '0;
        for (int i = 0; i < 4 && !got; i++) begin
            if (mv[0]) begin
                got = 1'b1;
                r   = mres[0];
                o   = movf[0];
            end else begin
                tick();
            end
        end
    endtask

    task automatic test_reset();
        aresetn  = 1'b1;
        sync_clr = 1'b0;
        s_valid  = 1'b0;
        s_sat    = 1'b0;
        s_a      = '0;
        s_b      = '0;
        s_op     = '0;
        mr       = '0;
        v8       = 1'b0;
        mr8      = 1'b0;
        a8       = '0;
        b8       = '0;
        op8      = '0;
        #2;
        aresetn = 1'b0;
        #10;
        checks++;
        if (mv !== 3'b000) begin
            fails++;
            $display("FAIL reset m_valid: got %b want 000", mv);
        end
        checks++;
        if (mres[0] !== 48'h0 || movf[0] !== 4'h0) begin
            fails++;
            $display("FAIL reset data: got %h/%h want 0/0", mres[0], movf[0]);
        end
        checks++;
        if (mv8 !== 1'b0 || mres8 !== 128'h0 || movf8 !== 8'h0) begin
            fails++;
            $display("FAIL reset lanes8: got %b %h %h want 0", mv8, mres8, movf8);
        end
        aresetn = 1'b1;
        tick();
        checks++;
        if (rdy !== 3'b111 || rdy8 !== 1'b1) begin
            fails++;
            $display("FAIL reset s_ready: got %b/%b want 111/1", rdy, rdy8);
        end
    endtask

    task automatic test_saturate_add();
        logic [47:0] r;
        logic [3:0]  o;
        logic        got;
        one_beat({12'hFFE, 12'h000, 12'h064, 12'h7FF},
                 {12'hFFF, 12'h000, 12'hFCE, 12'h001}, 4'b0000, 1'b1, r, o, got);
        checks++;
        if (!got || r !== {12'hFFD, 12'h000, 12'h032, 12'h7FF}) begin
            fails++;
            $display("FAIL add_sat res: got %h want ffd0000327ff", r);
        end
        checks++;
        if (o !== 4'b0001) begin
            fails++;
            $display("FAIL add_sat ovf: got %b want 0001", o);
        end
        one_beat({12'hFFE, 12'h000, 12'h064, 12'h7FF},
                 {12'hFFF, 12'h000, 12'hFCE, 12'h001}, 4'b0000, 1'b0, r, o, got);
        checks++;
        if (!got || r !== {12'hFFD, 12'h000, 12'h032, 12'h800}) begin
            fails++;
            $display("FAIL add_wrap res: got %h want ffd000032800", r);
        end
        checks++;
        if (o !== 4'b0001) begin
            fails++;
            $display("FAIL add_wrap ovf: got %b want 0001", o);
        end
    endtask

    task automatic test_subtract();
        logic [47:0] r;
        logic [3:0]  o;
        logic        got;
        one_beat({12'h7FF, 12'h3E8, 12'h005, 12'h800},
                 {12'h800, 12'h3E8, 12'h009, 12'h001}, 4'b1011, 1'b1, r, o, got);
        checks++;
        if (!got || r !== {12'h7FF, 12'h7D0, 12'hFFC, 12'h800}) begin
            fails++;
            $display("FAIL sub_sat res: got %h want 7ff7d0ffc800", r);
        end
        checks++;
        if (o !== 4'b1001) begin
            fails++;
            $display("FAIL sub_sat ovf: got %b want 1001", o);
        end
        one_beat({12'h7FF, 12'h3E8, 12'h005, 12'h800},
                 {12'h800, 12'h3E8, 12'h009, 12'h001}, 4'b1011, 1'b0, r, o, got);
        checks++;
        if (!got || r !== {12'hFFF, 12'h7D0, 12'hFFC, 12'h7FF}) begin
            fails++;
            $display("FAIL sub_wrap res: got %h want fff7d0ffc7ff", r);
        end
        checks++;
        if (o !== 4'b1001) begin
            fails++;
            $display("FAIL sub_wrap ovf: got %b want 1001", o);
        end
    endtask

    task automatic test_stream();
        int sent     = 0;
        int nrdy     = 0;
        int first_mv = -1;
        int last_mv  = -1;
        int nmv      = 0;
        flush();
        clear_sb();
        mr = 3'b111;
        for (int c = 0; c < 300; c++) begin
            s_valid = (sent < 100);
            s_a     = {16'($urandom), 32'($urandom)};
            s_b     = {16'($urandom), 32'($urandom)};
            s_op    = 4'($urandom);
            s_sat   = 1'($urandom);
            #1;
            if (s_valid && !rdy[0])
                nrdy++;
            if (mv[0]) begin
                if (first_mv < 0)
                    first_mv = c;
                last_mv = c;
                nmv++;
            end
            for (int g = 0; g < 3; g++) begin
                if (mv[g] && mr[g]) begin
                    checks++;
                    if (rd[g] >= wr[g]) begin
                        fails++;
                        $display("FAIL stream dut%0d: extra beat %h", g, mres[g]);
                    end else begin
                        if ({movf[g], mres[g]} !== expq[g][rd[g]]) begin
                            fails++;
                            $display("FAIL stream dut%0d beat %0d: got %h want %h",
                                     g, rd[g], {movf[g], mres[g]}, expq[g][rd[g]]);
                        end
                        rd[g]++;
                    end
                end
                if (s_valid && rdy[g]) begin
                    expq[g][wr[g]] = model(s_a, s_b, s_op, s_sat);
                    wr[g]++;
                end
            end
            if (s_valid && rdy[0])
                sent++;
            tick();
        end
        s_valid = 1'b0;
        checks++;
        if (nrdy != 0 || sent != 100) begin
            fails++;
            $display("FAIL stream throughput: stalls %0d sent %0d want 0/100", nrdy, sent);
        end
        checks++;
        if (first_mv != 2 || last_mv != 101 || nmv != 100) begin
            fails++;
            $display("FAIL stream timing: first %0d last %0d n %0d want 2/101/100",
                     first_mv, last_mv, nmv);
        end
        checks++;
        if (rd[0] != 100 || rd[1] != 100 || rd[2] != 100) begin
            fails++;
            $display("FAIL stream drained: got %0d %0d %0d want 100", rd[0], rd[1], rd[2]);
        end
    endtask

    task automatic test_backpressure();
        int          acc [3];
        int          n;
        int          n2;
        logic [47:0] got [4];
        flush();
        mr = 3'b000;
        for (int g = 0; g < 3; g++)
            acc[g] = 0;
        for (int i = 0; i < 6; i++) begin
            s_valid = 1'b1;
            s_a     = {4{12'(10 * i + 5)}};
            s_b     = {4{12'(i)}};
            s_op    = 4'b0000;
            s_sat   = 1'b1;
            #1;
            for (int g = 0; g < 3; g++)
                if (rdy[g])
                    acc[g]++;
            tick();
        end
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (acc[g] != g + 2) begin
                fails++;
                $display("FAIL bp capacity dut%0d: got %0d want %0d", g, acc[g], g + 2);
            end
        end
        checks++;
        if (rdy !== 3'b000) begin
            fails++;
            $display("FAIL bp s_ready: got %b want 000", rdy);
        end
        checks++;
        if (mv[0] !== 1'b1 || mres[0] !== {4{12'h005}} || movf[0] !== 4'h0) begin
            fails++;
            $display("FAIL bp held head: got %b %h want 1 %h", mv[0], mres[0], {4{12'h005}});
        end
        s_valid = 1'b0;
        mr      = 3'b111;
        n       = 0;
        n2      = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (mv[0] && n < 4) begin
                got[n] = mres[0];
                n++;
            end
            if (mv[2])
                n2++;
            tick();
        end
        checks++;
        if (n != 2 || got[0] !== {4{12'h005}} || got[1] !== {4{12'h010}}) begin
            fails++;
            $display("FAIL bp release order: n %0d got %h %h want 2 %h %h",
                     n, got[0], got[1], {4{12'h005}}, {4{12'h010}});
        end
        checks++;
        if (n2 != 4) begin
            fails++;
            $display("FAIL bp release dut2: got %0d beats want 4", n2);
        end
    endtask

    task automatic test_sync_clr();
        int seen = 0;
        flush();
        mr      = 3'b000;
        s_valid = 1'b1;
        s_a     = {4{12'h111}};
        s_b     = '0;
        s_op    = '0;
        s_sat   = 1'b0;
        tick();
        tick();
        checks++;
        if (mv[0] !== 1'b1 || rdy[0] !== 1'b0) begin
            fails++;
            $display("FAIL clr prefill: got mv %b rdy %b want 1/0", mv[0], rdy[0]);
        end
        s_a      = {4{12'h222}};
        mr       = 3'b111;
        sync_clr = 1'b1;
        #1;
        checks++;
        if (rdy !== 3'b000) begin
            fails++;
            $display("FAIL clr s_ready forced: got %b want 000", rdy);
        end
        tick();
        sync_clr = 1'b0;
        s_valid  = 1'b0;
        #1;
        checks++;
        if (mv !== 3'b000 || rdy !== 3'b111) begin
            fails++;
            $display("FAIL clr after: got mv %b rdy %b want 000/111", mv, rdy);
        end
        for (int c = 0; c < 5; c++) begin
            if (mv !== 3'b000)
                seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            fails++;
            $display("FAIL clr collided beat: got %0d valid cycles want 0", seen);
        end
    endtask

    task automatic test_async_reset();
        logic [47:0] r;
        logic [3:0]  o;
        logic        got;
        mr      = 3'b111;
        s_valid = 1'b1;
        s_a     = {4{12'h7FF}};
        s_b     = {4{12'h001}};
        s_op    = 4'b0000;
        s_sat   = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (mv[0] !== 1'b1 || mres[0] !== {4{12'h7FF}} || movf[0] !== 4'hF) begin
            fails++;
            $display("FAIL arst prestream: got %b %h %h want 1 %h f",
                     mv[0], mres[0], movf[0], {4{12'h7FF}});
        end
        aresetn = 1'b0;
        #1;
        checks++;
        if (mv !== 3'b000) begin
            fails++;
            $display("FAIL arst m_valid: got %b want 000", mv);
        end
        checks++;
        if (mres[0] !== 48'h0 || movf[0] !== 4'h0 || mres[2] !== 48'h0) begin
            fails++;
            $display("FAIL arst data: got %h %h %h want 0", mres[0], movf[0], mres[2]);
        end
        s_valid = 1'b0;
        aresetn = 1'b1;
        tick();
        one_beat({12'h000, 12'h001, 12'h7FF, 12'h800},
                 {12'h000, 12'h001, 12'h001, 12'h800}, 4'b0000, 1'b1, r, o, got);
        checks++;
        if (!got || r !== {12'h000, 12'h002, 12'h7FF, 12'h800} || o !== 4'b0011) begin
            fails++;
            $display("FAIL arst resume: got %h %b want 0000027ff800 0011", r, o);
        end
    endtask

    task automatic test_lanes8();
        v8   = 1'b1;
        mr8  = 1'b1;
        a8   = {16'h8000, 16'h0, 16'h0, 16'h0, 16'h0064, 16'h0, 16'h0, 16'h7FFF};
        b8   = {16'h0001, 16'h0, 16'h0, 16'h0, 16'h00C8, 16'h0, 16'h0, 16'h0001};
        op8  = 8'b1000_1000;
        s_sat = 1'b1;
        #1;
        checks++;
        if (rdy8 !== 1'b1) begin
            fails++;
            $display("FAIL lanes8 s_ready: got %b want 1", rdy8);
        end
        tick();
        v8 = 1'b0;
        tick();
        checks++;
        if (mv8 !== 1'b1
            || mres8 !== {16'h7FFF, 16'h0, 16'h0, 16'h0, 16'hFF9C, 16'h0, 16'h0, 16'h8000}) begin
            fails++;
            $display("FAIL lanes8 res: got %b %h want 1 7fff000000000000ff9c000000008000",
                     mv8, mres8);
        end
        checks++;
        if (movf8 !== 8'b1000_0001) begin
            fails++;
            $display("FAIL lanes8 ovf: got %b want 10000001", movf8);
        end
    endtask

    task automatic test_random_backpressure();
        logic        pv [3];
        logic        pm [3];
        logic [51:0] ph [3];
        flush();
        clear_sb();
        for (int g = 0; g < 3; g++) begin
            pv[g] = 1'b0;
            pm[g] = 1'b1;
            ph[g] = '0;
        end
        for (int c = 0; c < 340; c++) begin
            if (c < 300) begin
                s_valid = 1'($urandom);
                mr      = 3'($urandom);
            end else begin
                s_valid = 1'b0;
                mr      = 3'b111;
            end
            s_a   = {16'($urandom), 32'($urandom)};
            s_b   = {16'($urandom), 32'($urandom)};
            s_op  = 4'($urandom);
            s_sat = 1'($urandom);
            #1;
            for (int g = 0; g < 3; g++) begin
                if (pv[g] && !pm[g]) begin
                    checks++;
                    if (!mv[g] || {movf[g], mres[g]} !== ph[g]) begin
                        fails++;
                        $display("FAIL rand hold dut%0d cyc %0d: got %b %h want 1 %h",
                                 g, c, mv[g], {movf[g], mres[g]}, ph[g]);
                    end
                end
                pv[g] = mv[g];
                pm[g] = mr[g];
                ph[g] = {movf[g], mres[g]};
                if (mv[g] && mr[g]) begin
                    checks++;
                    if (rd[g] >= wr[g]) begin
                        fails++;
                        $display("FAIL rand dut%0d: extra beat %h", g, mres[g]);
                    end else begin
                        if ({movf[g], mres[g]} !== expq[g][rd[g]]) begin
                            fails++;
                            $display("FAIL rand dut%0d beat %0d: got %h want %h",
                                     g, rd[g], {movf[g], mres[g]}, expq[g][rd[g]]);
                        end
                        rd[g]++;
                    end
                end
                if (s_valid && rdy[g]) begin
                    expq[g][wr[g]] = model(s_a, s_b, s_op, s_sat);
                    wr[g]++;
                end
            end
            tick();
        end
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (rd[g] != wr[g] || wr[g] < 20) begin
                fails++;
                $display("FAIL rand drain dut%0d: emitted %0d accepted %0d", g, rd[g], wr[g]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_saturate_add();
        test_subtract();
        test_stream();
        test_backpressure();
        test_sync_clr();
        test_async_reset();
        test_lanes8();
        test_random_backpressure();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/simd_lane_addsub_pipe.md
Name: simd_lane_addsub_pipe

Overview:
Parametrised SIMD lane adder/subtractor. It processes LANES independent signed WIDTH-bit lanes per beat, with a per-lane add/sub select and optional saturation. Input and output use valid/ready handshakes, so the block can sit between the bicubic interpolation stream stages and absorb back-pressure without losing data. It replaces the fixed 4x12 add-only, enable-gated adder wherever a stream interface or subtraction is needed.

Parameters:
LANES, 4, number of independent lanes (1..8)
WIDTH, 12, signed lane width in bits (4..24)
PIPE_STAGES, 2, beat latency in cycles (2..4); stage 1 = input register, stage 2 = result register, extra stages = delay registers after the result
SATURATE, 1, 1 = saturation logic built and controlled by s_sat; 0 = logic omitted, always wrap

Ports:
clk  in  1  clock
aresetn  in  1  asynchronous active-low reset
sync_clr  in  1  synchronous pipeline flush, active high
s_valid  in  1  input beat valid
s_ready  out  1  block can accept a beat
s_a  in  LANES*WIDTH  operand A; lane i = bits [i*WIDTH +: WIDTH]
s_b  in  LANES*WIDTH  operand B, same packing
s_op  in  LANES  per-lane op: 0 = A+B, 1 = A-B
s_sat  in  1  1 = saturate this beat, 0 = wrap (ignored when SATURATE=0)
m_valid  out  1  result beat valid
m_ready  in  1  downstream accepts result
m_res  out  LANES*WIDTH  per-lane result, same packing
m_ovf  out  LANES  per-lane overflow flag, travels with m_res

Behaviour:
- Reset (aresetn low, async): all stage valid bits = 0, all data registers = 0. m_valid=0, m_res=0, m_ovf=0. s_ready=1 from the first cycle after reset release.
- Transfer: input on s_valid&&s_ready at a clk edge; output on m_valid&&m_ready.
- Pipeline: PIPE_STAGES stages, each with its own valid bit. Stage k loads when it is empty or stage k+1 loads (or, for the last stage, m_ready=1). Bubbles therefore collapse.
- s_ready = !v[1] || stage 2 loads. Combinational from m_ready through the stage chain; no combinational path from s_valid to s_ready.
- Latency: a beat accepted at edge t appears with m_valid=1 after edge t+PIPE_STAGES-1, provided no stall. Throughput is 1 beat/cycle with m_ready held high.
- Capacity is PIPE_STAGES beats. With m_ready=0 and continuous s_valid, exactly PIPE_STAGES beats are accepted, then s_ready=0. Order is always preserved; no beat is dropped or duplicated.
- Stalled output: m_res and m_ovf hold stable while m_valid=1 and m_ready=0.
- Arithmetic, per lane, between stage 1 and stage 2:
  - Form the (WIDTH+1)-bit signed result r = A + B, or A - B when s_op[i]=1.
  - Overflow: ovf = r[WIDTH] != r[WIDTH-1].
  - If ovf and saturation is active: result = +2^(WIDTH-1)-1 when r is positive, -2^(WIDTH-1) when r is negative.
  - Otherwise result = r[WIDTH-1:0] (wrap).
  - m_ovf[i] = ovf regardless of the saturation setting.
- s_op and s_sat are captured with the operands in stage 1 and apply to that beat only.
- sync_clr: clears all valid bits at the next edge and has priority over any load at that edge. A beat presented on the same edge is not accepted; s_ready is forced to 0 while sync_clr=1. Data registers need not be cleared.
- aresetn asserted mid-stream: in-flight beats are discarded immediately and outputs return to reset values.
- Simultaneous accept and emit with a full pipeline: both occur at the same edge and occupancy is unchanged.

Decomposition:
- Package simd_addsub_pkg:
  - op encoding constants OP_ADD=1'b0, OP_SUB=1'b1
  - functions sat_max(WIDTH) and sat_min(WIDTH)
  - lane-slice helper function
- Sub-module simd_lane_alu: one lane, purely combinational, implementing add/sub, overflow detect and saturation mux. It is generated LANES times inside the top; all pipeline and handshake logic lives in the top.

Test Plan:
- Defaults, single lane: A=2047, B=1, add, s_sat=1 -> res 2047, ovf=1. Same beat with s_sat=0 -> res -2048, ovf=1.
- Subtract: A=-2048, B=1, op=1, s_sat=1 -> res -2048, ovf=1. A=5, B=9, op=1 -> res -4, ovf=0. Mixed s_op across 4 lanes in one beat -> each lane independently correct.
- Streaming: 100 random beats with m_ready=1 -> one result per cycle, first m_valid 1 cycle after the first accept (PIPE_STAGES=2), matches the reference model in order.
- Back-pressure: m_ready=0 for 6 cycles with s_valid=1 -> exactly 2 beats accepted, then s_ready=0. Release -> all beats emerge in order with no loss. Repeat with random m_ready toggling across PIPE_STAGES=2,3,4.
- sync_clr with a full pipeline and s_valid=1 -> next cycle m_valid=0 and s_ready=1; the colliding input beat never appears at the output.
- aresetn pulsed low mid-stream -> m_valid=0, m_res=0, m_ovf=0 immediately; normal operation resumes after release. Also run LANES=8, WIDTH=16, SATURATE=0: 32767+1 -> -32768, ovf=1.
